// File: rtl/vga_sync.sv
// vga_sync: 640x480@60Hz VGA timing generator.
// Divides the system clock down to the pixel rate, runs the horizontal and
// vertical counters, and produces registered hsync/vsync/frame_tick plus a
// decoded video_on for the downstream graphics generator.
module vga_sync #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_RETRACE = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_RETRACE = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_RETRACE + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_RETRACE + V_BACK;
  // A one-bit divider is kept for CLK_DIV=1 so the register never has zero width.
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX        = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX        = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS        = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS        = 10'(V_DISPLAY);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_DISPLAY + H_FRONT + H_RETRACE - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_DISPLAY + V_FRONT + V_RETRACE - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic [9:0]       x_next;
  logic [9:0]       y_next;
  logic             h_end;
  logic             v_end;
  logic             hsync_act_next;
  logic             vsync_act_next;

  assign h_end = (pixel_x == H_MAX);
  assign v_end = (pixel_y == V_MAX);

  // Next-state decode for the divider, counters and sync windows.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    div_next = (div_cnt == DIV_MAX) ? '0 : div_cnt + 1'b1;
    x_next   = pixel_x;
    y_next   = pixel_y;
    if (p_tick) begin
      x_next = h_end ? 10'd0 : pixel_x + 10'd1;
      if (h_end) begin
        y_next = v_end ? 10'd0 : pixel_y + 10'd1;
      end
    end
    hsync_act_next = (x_next >= H_SYNC_FIRST) && (x_next <= H_SYNC_LAST);
    vsync_act_next = (y_next >= V_SYNC_FIRST) && (y_next <= V_SYNC_LAST);
  end

  // Timing state: syncs are registered from next-state counters so they line up with pixel_x/pixel_y.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt    <= '0;
      p_tick     <= 1'b0;
      pixel_x    <= 10'd0;
      pixel_y    <= 10'd0;
      hsync      <= ~SYNC_POL;
      vsync      <= ~SYNC_POL;
      frame_tick <= 1'b0;
    end else begin
      div_cnt    <= div_next;
      p_tick     <= (div_next == DIV_MAX);
      pixel_x    <= x_next;
      pixel_y    <= y_next;
      hsync      <= hsync_act_next ? SYNC_POL : ~SYNC_POL;
      vsync      <= vsync_act_next ? SYNC_POL : ~SYNC_POL;
      frame_tick <= p_tick & h_end & v_end;
    end
  end

  assign video_on = (pixel_x < H_VIS) && (pixel_y < V_VIS);

endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: directed bench for vga_sync.
// dut0 uses the default 640x480 timing at CLK_DIV=4; dut1 uses CLK_DIV=1,
// SYNC_POL=1 with the standard line but a 9-line frame so whole frames fit
// in a short run (frame = 800*9 = 7200 clks, vsync on line 6 only).
module tb_vga_sync;

  logic       clk = 1'b0;
  logic       rst0 = 1'b0;
  logic       rst1 = 1'b0;

  logic       p_tick0, video_on0, hsync0, vsync0, frame_tick0;
  logic [9:0] pixel_x0, pixel_y0;
  logic       p_tick1, video_on1, hsync1, vsync1, frame_tick1;
  logic [9:0] pixel_x1, pixel_y1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vga_sync dut0 (
    .clk        (clk),
    .reset      (rst0),
    .p_tick     (p_tick0),
    .pixel_x    (pixel_x0),
    .pixel_y    (pixel_y0),
    .video_on   (video_on0),
    .hsync      (hsync0),
    .vsync      (vsync0),
    .frame_tick (frame_tick0)
  );

  vga_sync #(
    .CLK_DIV   (1),
    .V_DISPLAY (4),
    .V_FRONT   (2),
    .V_RETRACE (1),
    .V_BACK    (2),
    .SYNC_POL  (1'b1)
  ) dut1 (
    .clk        (clk),
    .reset      (rst1),
    .p_tick     (p_tick1),
    .pixel_x    (pixel_x1),
    .pixel_y    (pixel_y1),
    .video_on   (video_on1),
    .hsync      (hsync1),
    .vsync      (vsync1),
    .frame_tick (frame_tick1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: outputs are sampled on the falling edge, away from the active edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Divider start-up after reset release on dut0 (release happens at a negedge).
  task automatic check_startup0();
    for (int c = 1; c <= 8; c++) begin
      step();
      check($sformatf("startup_ptick_c%0d", c), 32'(p_tick0), 32'((c % 4) == 3));
      check($sformatf("startup_x_c%0d", c), 32'(pixel_x0), 32'(c / 4));
    end
  endtask

  int  lo_cnt, lo_first, lo_last, vid_cnt, vid_last, x_max, budget;
  int  vs_cnt, hs_line0, ptick_low, ft_cnt, ft_first, ft_second, y_max, prev_x, prev_y;
  bit  found;

  initial begin
    // ---- reset state, both DUTs ----
    repeat (3) step();
    check("rst0_x", 32'(pixel_x0), 32'd0);
    check("rst0_y", 32'(pixel_y0), 32'd0);
    check("rst0_ptick", 32'(p_tick0), 32'd0);
    check("rst0_hsync", 32'(hsync0), 32'd1);
    check("rst0_vsync", 32'(vsync0), 32'd1);
    check("rst0_ftick", 32'(frame_tick0), 32'd0);
    check("rst0_video", 32'(video_on0), 32'd1);
    check("rst1_hsync", 32'(hsync1), 32'd0);
    check("rst1_vsync", 32'(vsync1), 32'd0);

    // ---- test 1: divider start-up ----
    rst0 = 1'b1;
    check_startup0();

    // ---- test 2: rest of line 0 (x = 2..799), one sample per pixel ----
    lo_cnt = 0; lo_first = -1; lo_last = -1; vid_cnt = 0; vid_last = -1; x_max = 0;
    found = 1'b0;
    for (int c = 0; c < 3300 && !found; c++) begin
      step();
      if (p_tick0) begin
        if (pixel_x0 == 10'd0) begin
          found = 1'b1;
        end else begin
          if (int'(pixel_x0) > x_max) x_max = int'(pixel_x0);
          if (!hsync0) begin
            lo_cnt++;
            if (lo_first < 0) lo_first = int'(pixel_x0);
            lo_last = int'(pixel_x0);
          end
          if (video_on0) begin
            vid_cnt++;
            vid_last = int'(pixel_x0);
          end
        end
      end
    end
    check("line_wrap_seen", 32'(found), 32'd1);
    check("line_x_max", 32'(x_max), 32'd799);
    check("line_hsync_low_cnt", 32'(lo_cnt), 32'd96);
    check("line_hsync_first", 32'(lo_first), 32'd656);
    check("line_hsync_last", 32'(lo_last), 32'd751);
    check("line_video_cnt", 32'(vid_cnt), 32'd638);
    check("line_video_last", 32'(vid_last), 32'd639);
    check("line_y_after_wrap", 32'(pixel_y0), 32'd1);
    check("line_vsync_y1", 32'(vsync0), 32'd1);

    // ---- test 4 (dut0): reset mid-line at x=700 ----
    found = 1'b0;
    for (int c = 0; c < 3300 && !found; c++) begin
      step();
      if (pixel_x0 == 10'd700) found = 1'b1;
    end
    check("mid0_reached", 32'(found), 32'd1);
    check("mid0_hsync", 32'(hsync0), 32'd0);
    check("mid0_video", 32'(video_on0), 32'd0);
    rst0 = 1'b0;
    #1;
    check("mid0_rst_x", 32'(pixel_x0), 32'd0);
    check("mid0_rst_y", 32'(pixel_y0), 32'd0);
    check("mid0_rst_hsync", 32'(hsync0), 32'd1);
    check("mid0_rst_ptick", 32'(p_tick0), 32'd0);
    check("mid0_rst_video", 32'(video_on0), 32'd1);
    repeat (2) step();
    rst0 = 1'b1;
    check_startup0();

    // ---- test 5 + 3 + 6 (dut1): CLK_DIV=1, active-high sync, two frames ----
    rst1 = 1'b1;
    vs_cnt = 0; hs_line0 = 0; ptick_low = 0; vid_cnt = 0; ft_cnt = 0;
    ft_first = -1; ft_second = -1; x_max = 0; y_max = 0; prev_x = 0; prev_y = 0;
    for (int c = 1; c <= 14402; c++) begin
      step();
      if (!p_tick1) ptick_low++;
      if (c == 2) check("d1_x_after_2clk", 32'(pixel_x1), 32'd1);
      if (c <= 7200) begin
        if (vsync1) vs_cnt++;
        if (hsync1 && pixel_y1 == 10'd0) hs_line0++;
        if (video_on1) vid_cnt++;
        if (int'(pixel_x1) > x_max) x_max = int'(pixel_x1);
        if (int'(pixel_y1) > y_max) y_max = int'(pixel_y1);
      end
      if (frame_tick1) begin
        ft_cnt++;
        if (ft_first < 0) begin
          ft_first = c;
          check("wrap_prev_x", 32'(prev_x), 32'd799);
          check("wrap_prev_y", 32'(prev_y), 32'd8);
          check("wrap_x", 32'(pixel_x1), 32'd0);
          check("wrap_y", 32'(pixel_y1), 32'd0);
          check("wrap_video", 32'(video_on1), 32'd1);
          check("wrap_vsync", 32'(vsync1), 32'd0);
        end else if (ft_second < 0) begin
          ft_second = c;
        end
      end
      prev_x = int'(pixel_x1);
      prev_y = int'(pixel_y1);
    end
    check("d1_ptick_low_cnt", 32'(ptick_low), 32'd0);
    check("d1_hsync_hi_line0", 32'(hs_line0), 32'd96);
    check("d1_vsync_hi_cnt", 32'(vs_cnt), 32'd800);
    check("d1_video_cnt", 32'(vid_cnt), 32'd2560);
    check("d1_x_max", 32'(x_max), 32'd799);
    check("d1_y_max", 32'(y_max), 32'd8);
    check("d1_ftick_cnt", 32'(ft_cnt), 32'd2);
    check("d1_ftick_first", 32'(ft_first), 32'd7201);
    check("d1_ftick_second", 32'(ft_second), 32'd14401);
    check("d1_ftick_one_clk", 32'(frame_tick1), 32'd0);

    // ---- test 4 (dut1): reset at x=700 on the vsync line, both syncs active ----
    found = 1'b0;
    for (int c = 0; c < 8000 && !found; c++) begin
      step();
      if (pixel_x1 == 10'd700 && pixel_y1 == 10'd6) found = 1'b1;
    end
    check("mid1_reached", 32'(found), 32'd1);
    check("mid1_hsync", 32'(hsync1), 32'd1);
    check("mid1_vsync", 32'(vsync1), 32'd1);
    rst1 = 1'b0;
    #1;
    check("mid1_rst_x", 32'(pixel_x1), 32'd0);
    check("mid1_rst_y", 32'(pixel_y1), 32'd0);
    check("mid1_rst_hsync", 32'(hsync1), 32'd0);
    check("mid1_rst_vsync", 32'(vsync1), 32'd0);
    check("mid1_rst_ftick", 32'(frame_tick1), 32'd0);
    check("mid1_rst_ptick", 32'(p_tick1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
